// File: rtl/dm_sram_responder.sv
// Data-memory responder for the CPU SRAM port: clears its array with a sweep after
// reset, then serves one masked write or registered read per cycle and counts accesses.
module dm_sram_responder #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CEB,
  input  logic                  WEB,
  input  logic [DATA_WIDTH-1:0] BWEB,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] DI,
  output logic [DATA_WIDTH-1:0] DO,
  output logic                  init_done,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [ADDR_WIDTH-1:0]   ptr_r;
  logic [DATA_WIDTH-1:0]   do_r;
  logic                    init_done_r;
  logic [31:0]             rd_count_r;
  logic [31:0]             wr_count_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_s;
  logic                    rd_acc_s;
  logic                    wr_acc_s;

  // Next-state decode and selection of the single array write port (sweep or CPU write).
  always_comb begin
    state_next_s = state_r;
    mem_we_s     = 1'b0;
    mem_addr_s   = A;
    mem_wdata_s  = {DATA_WIDTH{1'b0}};
    rd_acc_s     = 1'b0;
    wr_acc_s     = 1'b0;
    case (state_r)
      ST_INIT: begin
        mem_we_s   = 1'b1;
        mem_addr_s = ptr_r;
        if (ptr_r == {ADDR_WIDTH{1'b1}}) begin
          state_next_s = ST_READY;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_READY: begin
        if (!CEB) begin
          if (WEB) begin
            rd_acc_s = 1'b1;
          end else begin
            // Masked bits keep the stored value; unmasked bits take DI.
            wr_acc_s    = 1'b1;
            mem_we_s    = 1'b1;
            mem_wdata_s = (mem_r[A] & BWEB) | (DI & ~BWEB);
          end
        end else begin
          rd_acc_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase
  end

  // Control state, sweep pointer, read data and access counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_INIT;
      ptr_r       <= {ADDR_WIDTH{1'b0}};
      do_r        <= {DATA_WIDTH{1'b0}};
      init_done_r <= 1'b0;
      rd_count_r  <= 32'd0;
      wr_count_r  <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      init_done_r <= (state_next_s == ST_READY);
      if (state_r == ST_INIT) begin
        ptr_r <= ptr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      if (rd_acc_s) begin
        do_r       <= mem_r[A];
        rd_count_r <= rd_count_r + 32'd1;
      end
      if (wr_acc_s) begin
        wr_count_r <= wr_count_r + 32'd1;
      end
    end
  end

  // Storage array; contents are cleared by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign DO        = do_r;
  assign init_done = init_done_r;
  assign rd_count  = rd_count_r;
  assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_dm_sram_responder.sv
// Randomized self-checking bench for dm_sram_responder (ADDR_WIDTH=4) against an
// array-based reference model of the memory, counters and read-data register.
module tb_dm_sram_responder;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          ceb;
  logic          web;
  logic [DW-1:0] bweb;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          init_done;
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_do;
  logic [31:0]   ref_rd;
  logic [31:0]   ref_wr;

  int total_cnt;
  int bad_cnt;

  dm_sram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .CEB       (ceb),
    .WEB       (web),
    .BWEB      (bweb),
    .A         (addr),
    .DI        (din),
    .DO        (dout),
    .init_done (init_done),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, " DO"}, dout, ref_do);
    check_val({tag, " rd_count"}, rd_count, ref_rd);
    check_val({tag, " wr_count"}, wr_count, ref_wr);
    check_val({tag, " init_done"}, {31'd0, init_done}, 32'd1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    ref_do = 32'h0;
    ref_rd = 32'd0;
    ref_wr = 32'd0;
  endtask

  // One access in READY; called at a negedge, returns at the next negedge after checking.
  task automatic access(input logic c, input logic w, input logic [DW-1:0] m,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    ceb  = c;
    web  = w;
    bweb = m;
    addr = a;
    din  = d;
    @(posedge clk);
    if (!c) begin
      if (w) begin
        ref_do = ref_mem[a];
        ref_rd = ref_rd + 32'd1;
      end else begin
        for (int b = 0; b < DW; b++) begin
          if (!m[b]) ref_mem[a][b] = d[b];
        end
        ref_wr = ref_wr + 32'd1;
      end
    end
    @(negedge clk);
    check_outputs(tag);
    ceb = 1'b1;
  endtask

  // Release reset and watch the 16-cycle sweep while a write is driven (it must be ignored).
  task automatic run_sweep(input string tag);
    ceb  = 1'b0;
    web  = 1'b0;
    bweb = 32'h0;
    addr = 4'd2;
    din  = 32'hFFFF_FFFF;
    rst  = 1'b0;
    model_reset();
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_val({tag, " init_done"}, {31'd0, init_done}, (k == DEPTH) ? 32'd1 : 32'd0);
      check_val({tag, " DO"}, dout, 32'h0);
      check_val({tag, " rd_count"}, rd_count, 32'd0);
      check_val({tag, " wr_count"}, wr_count, 32'd0);
    end
    ceb = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] m;
    logic [DW-1:0] d;
    int            sel;
    total_cnt = 0;
    bad_cnt   = 0;
    rst  = 1'b1;
    ceb  = 1'b1;
    web  = 1'b1;
    bweb = 32'hFFFF_FFFF;
    addr = 4'd0;
    din  = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset DO", dout, 32'h0);
    check_val("reset init_done", {31'd0, init_done}, 32'd0);
    check_val("reset rd_count", rd_count, 32'd0);
    check_val("reset wr_count", wr_count, 32'd0);

    run_sweep("sweep1");
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'hFFFF_FFFF, i[AW-1:0], 32'h0, "clear read");

    access(1'b0, 1'b0, 32'h0, 4'd3, 32'hDEAD_BEEF, "full write");
    access(1'b0, 1'b1, 32'hFFFF_FFFF, 4'd3, 32'h0, "full read");
    check_val("full read value", dout, 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 32'hFFFF_00FF, 4'd3, 32'h1234_5678, "masked write");
    access(1'b0, 1'b0, 32'hFFFF_FFFF, 4'd3, 32'h0BAD_F00D, "no-bit write");
    check_val("no-bit write count", wr_count, 32'd3);
    access(1'b0, 1'b1, 32'hFFFF_FFFF, 4'd3, 32'h0, "masked read");
    check_val("masked read value", dout, 32'hDEAD_56EF);
    for (int i = 0; i < 5; i++) access(1'b1, 1'b1, 32'h0, 4'd3, 32'hCAFE_0000, "idle");
    access(1'b0, 1'b0, 32'h0, 4'd5, 32'h5555_AAAA, "write holds DO");
    check_val("hold value", dout, 32'hDEAD_56EF);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 3);
      m = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : 32'($urandom);
      d = 32'($urandom);
      access(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, m,
             4'($urandom_range(0, DEPTH - 1)), d, "random");
    end

    access(1'b0, 1'b0, 32'h0, 4'd7, 32'hA5A5_A5A5, "pre-reset write");
    #2 rst = 1'b1;
    #1;
    check_val("async rst DO", dout, 32'h0);
    check_val("async rst init_done", {31'd0, init_done}, 32'd0);
    check_val("async rst rd_count", rd_count, 32'd0);
    check_val("async rst wr_count", wr_count, 32'd0);
    @(negedge clk);
    run_sweep("sweep2");
    access(1'b0, 1'b1, 32'hFFFF_FFFF, 4'd7, 32'h0, "post-reset read7");
    check_val("post-reset A7", dout, 32'h0);
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'hFFFF_FFFF, i[AW-1:0], 32'h0, "re-clear read");
    access(1'b0, 1'b1, 32'hFFFF_FFFF, 4'd2, 32'h0, "init write ignored");
    check_val("init write A2", dout, 32'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
